// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: main + skid entry with a fully registered
// upstream ready, hold/flush control and saturating stall/flush counters.
module pipe_stage_buf #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_next;
  logic [DATA_W-1:0] w_skid_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_push;
  logic              w_pop;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready & ~hold;
  assign w_stall_inc = out_valid & (~out_ready | hold) & ~flush;
  assign w_flush_inc = flush & (r_state != ST_EMPTY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
    end
  end

  // Vacated registers are reloaded with RESET_VAL so out_data is a bubble when idle.
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (flush) begin
      w_state_next = ST_EMPTY;
      w_main_next  = RESET_VAL;
      w_skid_next  = RESET_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_next = ST_ONE;
            w_main_next  = in_data;
          end
        end
        ST_ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              w_state_next = ST_FULL;
              w_skid_next  = in_data;
            end
            2'b11: begin
              w_main_next = in_data;
            end
            2'b01: begin
              w_state_next = ST_EMPTY;
              w_main_next  = RESET_VAL;
            end
            default: begin
            end
          endcase
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_next = ST_ONE;
            w_main_next  = r_skid;
            w_skid_next  = RESET_VAL;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
          w_main_next  = RESET_VAL;
          w_skid_next  = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: directed pushes queue their expected
// payloads, a negedge monitor checks every delivered word in order.
module tb_pipe_stage_buf;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        hold;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        s_flush;
  logic        s_hold;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;
  logic [3:0]  s_flush_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  pipe_stage_buf #(.DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_buf #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(s_flush), .hold(s_hold),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic rdy,
                       input logic hd, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    hold      = hd;
    flush     = fl;
  endtask

  // One clock: an accepted, non-flushed push queues the word the bench drove.
  task automatic tick();
    @(negedge clk);
    if (reset && in_valid && in_ready && !flush) exp_q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop occurs at the coming posedge, so the head word is on out_data now.
  always @(negedge clk) begin
    if (reset) begin
      if (!out_valid) check("idle_bubble", out_data, 64'h0);
      if (out_valid && out_ready && !hold) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got %h expected no output at %0t", out_data, $time);
        end else begin
          check("out_order", out_data, exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    s_flush = 1'b0; s_hold = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h0; s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_occupancy", 64'(occupancy), 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'h0);
    reset = 1'b1;

    // Streaming 1..8 back to back
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 64'(k), 1'b1, 1'b0, 1'b0);
      tick();
      check("stream_valid", 64'(out_valid), 64'h1);
      check("stream_latency", out_data, 64'(k));
      check("stream_occ_le1", 64'(occupancy <= 2'd1), 64'h1);
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stream_drained", 64'(occupancy), 64'h0);
    check("stream_stall_cnt", 64'(stall_cnt), 64'h0);

    // Backpressure: A, B fill the stage, C waits upstream
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_occ_full", 64'(occupancy), 64'h2);
    check("bp_in_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_still_full", 64'(occupancy), 64'h2);
    check("bp_head", out_data, 64'hA);
    drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp_drained", 64'(occupancy), 64'h0);
    check("bp_stall_cnt", 64'(stall_cnt), 64'd2);

    // Hold: FULL with 0x11/0x22, hold for 3 cycles with out_ready high
    drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    tick();
    check("hold_pre_stall", 64'(stall_cnt), 64'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
      tick();
      check("hold_data", out_data, 64'h11);
      check("hold_occ", 64'(occupancy), 64'h2);
    end
    check("hold_stall_cnt", 64'(stall_cnt), 64'd6);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("hold_drained", 64'(occupancy), 64'h0);

    // Flush while FULL with a push of 0x33 in the same cycle
    drive(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h66, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h33, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'h0);
    check("flush_out_data", out_data, 64'h0);
    check("flush_occupancy", 64'(occupancy), 64'h0);
    check("flush_in_ready", 64'(in_ready), 64'h1);
    check("flush_cnt_full", 64'(flush_cnt), 64'd1);
    check("flush_stall_cnt", 64'(stall_cnt), 64'd7);
    tick();
    check("flush_no_33", 64'(out_valid), 64'h0);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    tick();
    check("flush_empty_cnt", 64'(flush_cnt), 64'd1);
    // Flush coinciding with a delivery of 0x77
    drive(1'b1, 64'h77, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("flush_pop_cnt", 64'(flush_cnt), 64'd2);
    check("flush_pop_occ", 64'(occupancy), 64'h0);

    // Asynchronous reset while FULL, between clock edges
    drive(1'b1, 64'h88, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    check("pre_areset_occ", 64'(occupancy), 64'h2);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("areset_out_valid", 64'(out_valid), 64'h0);
    check("areset_occupancy", 64'(occupancy), 64'h0);
    check("areset_stall_cnt", 64'(stall_cnt), 64'h0);
    check("areset_flush_cnt", 64'(flush_cnt), 64'h0);
    check("areset_in_ready", 64'(in_ready), 64'h1);
    check("areset_out_data", out_data, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 64'h44, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_reset_valid", 64'(out_valid), 64'h1);
    check("post_reset_data", out_data, 64'h44);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();

    // Saturation on the 4-bit counter instance
    s_in_valid = 1'b1;
    s_in_data  = 8'h5A;
    tick();
    s_in_valid = 1'b0;
    check("sat_valid", 64'(s_out_valid), 64'h1);
    repeat (14) tick();
    check("sat_cnt_14", 64'(s_stall_cnt), 64'd14);
    tick();
    check("sat_cnt_15", 64'(s_stall_cnt), 64'd15);
    repeat (5) tick();
    check("sat_cnt_hold", 64'(s_stall_cnt), 64'd15);
    check("sat_data", 64'(s_out_data), 64'h5A);

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
